// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_issue_ctrl_if : decode / unit / writeback bundle for the issuer   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int RD_W  = 3
) ();
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_opcode;
  logic [WIDTH-1:0] in_rs1;
  logic [WIDTH-1:0] in_rs2;
  logic [RD_W-1:0]  in_rd;
  logic             fu_start;
  logic [3:0]       fu_sel;
  logic [WIDTH-1:0] fu_rs1;
  logic [WIDTH-1:0] fu_rs2;
  logic [3:0]       fu_done;
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH-1:0] mul_res;
  logic [WIDTH-1:0] div_res;
  logic             wb_valid;
  logic             wb_ready;
  logic [RD_W-1:0]  wb_rd;
  logic [WIDTH-1:0] wb_data;
  logic             wb_err;
  logic             busy;

  // Environment side: decode, arithmetic units and register file.
  modport master (
    output in_valid, in_opcode, in_rs1, in_rs2, in_rd,
    output fu_done, add_res, sub_res, mul_res, div_res, wb_ready,
    input  in_ready, fu_start, fu_sel, fu_rs1, fu_rs2,
    input  wb_valid, wb_rd, wb_data, wb_err, busy
  );

  // Controller side.
  modport slave (
    input  in_valid, in_opcode, in_rs1, in_rs2, in_rd,
    input  fu_done, add_res, sub_res, mul_res, div_res, wb_ready,
    output in_ready, fu_start, fu_sel, fu_rs1, fu_rs2,
    output wb_valid, wb_rd, wb_data, wb_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_issue_ctrl : one-op-in-flight sequencer for add/sub/mul/div units |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_issue_ctrl #(
  parameter int WIDTH   = 16,
  parameter int RD_W    = 3,
  parameter int TIMEOUT = 64
) (
  input  wire logic     clk,
  input  wire logic     rst,
  alu_issue_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] rs1_q, rs1_d;
  logic [WIDTH-1:0] rs2_q, rs2_d;
  logic [RD_W-1:0]  rd_q, rd_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]       sel_onehot;
  logic             done_hit;
  logic [WIDTH-1:0] res_mux;

  always_comb begin
    sel_onehot = 4'b0000;
    res_mux    = '0;
    case (op_q)
      2'd0: begin sel_onehot = 4'b0001; res_mux = bus.add_res; end
      2'd1: begin sel_onehot = 4'b0010; res_mux = bus.sub_res; end
      2'd2: begin sel_onehot = 4'b0100; res_mux = bus.mul_res; end
      default: begin sel_onehot = 4'b1000; res_mux = bus.div_res; end
    endcase
    // Only the selected unit's done bit can complete the op.
    done_hit = |(bus.fu_done & sel_onehot);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d  = bus.in_opcode;
          rs1_d = bus.in_rs1;
          rs2_d = bus.in_rs2;
          rd_d  = bus.in_rd;
          if (bus.in_opcode == 2'd3 && bus.in_rs2 == '0) begin
            data_d  = '1;
            err_d   = 1'b1;
            state_d = S_WB;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (done_hit) begin
          data_d  = res_mux;
          err_d   = 1'b0;
          state_d = S_WB;
        end else begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Done is tested first so it wins over a coincident timeout.
        if (done_hit) begin
          data_d  = res_mux;
          err_d   = 1'b0;
          state_d = S_WB;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (bus.wb_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready = (state_q == S_IDLE);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.fu_start = (state_q == S_ISSUE);
  assign bus.fu_sel   = (state_q == S_ISSUE || state_q == S_WAIT) ? sel_onehot : 4'b0000;
  assign bus.fu_rs1   = rs1_q;
  assign bus.fu_rs2   = rs2_q;
  assign bus.wb_valid = (state_q == S_WB);
  assign bus.wb_rd    = rd_q;
  assign bus.wb_data  = data_q;
  assign bus.wb_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_issue_ctrl : directed self-checking bench for alu_issue_ctrl   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_alu_issue_ctrl;

  localparam int WIDTH   = 16;
  localparam int RD_W    = 3;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_issue_ctrl_if #(.WIDTH(WIDTH), .RD_W(RD_W)) bus ();

  alu_issue_ctrl #(.WIDTH(WIDTH), .RD_W(RD_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, ".busy"},     32'(bus.busy),     32'd0);
    chk({tag, ".fu_start"}, 32'(bus.fu_start), 32'd0);
    chk({tag, ".fu_sel"},   32'(bus.fu_sel),   32'd0);
    chk({tag, ".wb_valid"}, 32'(bus.wb_valid), 32'd0);
    chk({tag, ".wb_err"},   32'(bus.wb_err),   32'd0);
    chk({tag, ".wb_data"},  32'(bus.wb_data),  32'd0);
    chk({tag, ".wb_rd"},    32'(bus.wb_rd),    32'd0);
    chk({tag, ".fu_rs1"},   32'(bus.fu_rs1),   32'd0);
    chk({tag, ".fu_rs2"},   32'(bus.fu_rs2),   32'd0);
  endtask

  task automatic accept(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] rd);
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_rs1    = a;
    bus.in_rs2    = b;
    bus.in_rd     = rd;
    step();
    bus.in_valid  = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_opcode = 2'd0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_rd     = '0;
    bus.fu_done   = 4'b0000;
    bus.add_res   = 16'h0008;
    bus.sub_res   = 16'h0005;
    bus.mul_res   = 16'h0040;
    bus.div_res   = 16'h1234;
    bus.wb_ready  = 1'b0;

    // Reset values
    step();
    step();
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Add, unit done in its start cycle
    accept(2'd0, 16'h0005, 16'h0003, 3'd2);
    chk("add.fu_start", 32'(bus.fu_start), 32'd1);
    chk("add.fu_sel",   32'(bus.fu_sel),   32'b0001);
    chk("add.fu_rs1",   32'(bus.fu_rs1),   32'h0005);
    chk("add.fu_rs2",   32'(bus.fu_rs2),   32'h0003);
    chk("add.in_ready", 32'(bus.in_ready), 32'd0);
    chk("add.busy",     32'(bus.busy),     32'd1);
    chk("add.wb_early", 32'(bus.wb_valid), 32'd0);
    bus.fu_done = 4'b0001;
    step();
    bus.fu_done = 4'b0000;
    chk("add.wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("add.wb_rd",    32'(bus.wb_rd),    32'd2);
    chk("add.wb_data",  32'(bus.wb_data),  32'h0008);
    chk("add.wb_err",   32'(bus.wb_err),   32'd0);
    chk("add.start_once", 32'(bus.fu_start), 32'd0);
    chk("add.sel_wb",   32'(bus.fu_sel),   32'd0);
    bus.wb_ready = 1'b1;
    step();
    bus.wb_ready = 1'b0;
    chk("add.idle_ready", 32'(bus.in_ready), 32'd1);
    chk("add.idle_wbv",   32'(bus.wb_valid), 32'd0);

    // Mul, done 3 cycles after start
    accept(2'd2, 16'h0010, 16'h0004, 3'd5);
    chk("mul.fu_start", 32'(bus.fu_start), 32'd1);
    chk("mul.fu_sel",   32'(bus.fu_sel),   32'b0100);
    for (int i = 2; i <= 4; i++) begin
      step();
      chk("mul.wait_start", 32'(bus.fu_start), 32'd0);
      chk("mul.wait_sel",   32'(bus.fu_sel),   32'b0100);
      chk("mul.wait_rs1",   32'(bus.fu_rs1),   32'h0010);
      chk("mul.wait_rs2",   32'(bus.fu_rs2),   32'h0004);
      chk("mul.wait_wbv",   32'(bus.wb_valid), 32'd0);
    end
    bus.fu_done = 4'b0100;
    step();
    bus.fu_done = 4'b0000;
    chk("mul.wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("mul.wb_data",  32'(bus.wb_data),  32'h0040);
    chk("mul.wb_err",   32'(bus.wb_err),   32'd0);
    chk("mul.wb_rd",    32'(bus.wb_rd),    32'd5);
    bus.wb_ready = 1'b1;
    step();
    bus.wb_ready = 1'b0;

    // Divide by zero: straight to writeback
    accept(2'd3, 16'h0077, 16'h0000, 3'd7);
    chk("dz.fu_start", 32'(bus.fu_start), 32'd0);
    chk("dz.fu_sel",   32'(bus.fu_sel),   32'd0);
    chk("dz.wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("dz.wb_data",  32'(bus.wb_data),  32'hFFFF);
    chk("dz.wb_err",   32'(bus.wb_err),   32'd1);
    chk("dz.wb_rd",    32'(bus.wb_rd),    32'd7);
    bus.wb_ready = 1'b1;
    step();
    bus.wb_ready = 1'b0;

    // Div timeout; a non-selected add done during WAIT must be ignored
    accept(2'd3, 16'h0064, 16'h0005, 3'd1);
    chk("to.fu_sel", 32'(bus.fu_sel), 32'b1000);
    for (int i = 2; i <= TIMEOUT + 1; i++) begin
      bus.fu_done = 4'b0111;
      step();
      chk("to.wait_wbv", 32'(bus.wb_valid), 32'd0);
      chk("to.wait_sel", 32'(bus.fu_sel),   32'b1000);
    end
    step();
    bus.fu_done = 4'b0000;
    chk("to.wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("to.wb_data",  32'(bus.wb_data),  32'h0000);
    chk("to.wb_err",   32'(bus.wb_err),   32'd1);
    chk("to.wb_rd",    32'(bus.wb_rd),    32'd1);
    bus.wb_ready = 1'b1;
    step();
    bus.wb_ready = 1'b0;
    bus.fu_done  = 4'b1000;
    step();
    step();
    bus.fu_done  = 4'b0000;
    chk("stray.in_ready", 32'(bus.in_ready), 32'd1);
    chk("stray.busy",     32'(bus.busy),     32'd0);
    chk("stray.wb_valid", 32'(bus.wb_valid), 32'd0);

    // Sub with writeback back-pressure for 4 cycles
    accept(2'd1, 16'h0009, 16'h0004, 3'd3);
    bus.fu_done = 4'b0010;
    step();
    bus.fu_done = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      chk("bp.wb_valid", 32'(bus.wb_valid), 32'd1);
      chk("bp.wb_rd",    32'(bus.wb_rd),    32'd3);
      chk("bp.wb_data",  32'(bus.wb_data),  32'h0005);
      chk("bp.wb_err",   32'(bus.wb_err),   32'd0);
      chk("bp.in_ready", 32'(bus.in_ready), 32'd0);
      if (i < 3) step();
    end
    bus.wb_ready = 1'b1;
    step();
    bus.wb_ready = 1'b0;
    chk("bp.after_ready", 32'(bus.in_ready), 32'd1);
    chk("bp.after_wbv",   32'(bus.wb_valid), 32'd0);

    // Reset during a mul WAIT, then a late mul done
    accept(2'd2, 16'h0003, 16'h0006, 3'd4);
    step();
    chk("rw.in_wait", 32'(bus.fu_sel), 32'b0100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_outputs("rw.reset");
    bus.fu_done = 4'b0100;
    step();
    bus.fu_done = 4'b0000;
    chk_reset_outputs("rw.late_done");
    step();
    chk("rw.no_wb", 32'(bus.wb_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
